// File: rtl/dsp_mac_sequencer_if.sv
// Operand and result valid/ready streams of the dsp_mac_sequencer.
// The master side drives operands and consumes results; the slave side is the sequencer.
interface dsp_mac_sequencer_if #(
    parameter int DW = 18
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [47:0]   out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as an unsigned N-term multiply-accumulate engine.
// Optional abort input and slice P reset pulse when MAC_SEQ_ABORT_EN is defined.
module dsp_mac_sequencer #(
    parameter int DW    = 18,
    parameter int LEN_W = 8,
    parameter int MLAT  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
`ifdef MAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    dsp_mac_sequencer_if.slave mac,
    output logic [DW-1:0]    dsp_A,
    output logic [DW-1:0]    dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_RSTP,
    input  logic [47:0]      dsp_P
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {T_BUBBLE, T_FIRST, T_ACC} tag_t;

    state_t           state, state_nxt;
    tag_t             tag_p [MLAT];
    tag_t             tag_in;
    logic [LEN_W-1:0] len_q, acc_cnt, ret_cnt;
    logic             in_rdy, accept, retire, last_retire, kill;
    logic             last_p1, last_p2;
    logic             out_vld;
    logic [47:0]      result;

    function automatic logic [7:0] tag_opmode(input tag_t t);
        case (t)
            T_FIRST: return 8'h01;
            T_ACC:   return 8'h09;
            default: return 8'h08;
        endcase
    endfunction

`ifdef MAC_SEQ_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    // in_ready is withheld during an abort so no operand is silently dropped.
    assign in_rdy      = (state == ACCUM) && (acc_cnt < len_q) && !kill;
    assign accept      = mac.in_valid && in_rdy;
    assign tag_in      = !accept ? T_BUBBLE : ((acc_cnt == '0) ? T_FIRST : T_ACC);
    assign retire      = (tag_p[MLAT-1] != T_BUBBLE);
    assign last_retire = retire && (ret_cnt == len_q - 1'b1);

    assign busy          = (state != IDLE);
    assign mac.in_ready  = in_rdy;
    assign mac.out_valid = out_vld;
    assign mac.out_data  = result;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start && (cfg_len != '0))                state_nxt = ACCUM;
            ACCUM: if (accept && (acc_cnt == len_q - 1'b1))     state_nxt = DRAIN;
            DRAIN: if (last_p2)                                 state_nxt = DONE;
            DONE:  if (out_vld && mac.out_ready)                state_nxt = IDLE;
            default:                                            state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Tag pipe mirrors the slice A0/A1/M stages; dsp_OPMODE is the OPMODE register feed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q      <= '0;
            acc_cnt    <= '0;
            ret_cnt    <= '0;
            last_p1    <= 1'b0;
            last_p2    <= 1'b0;
            out_vld    <= 1'b0;
            dsp_OPMODE <= 8'h00;
            for (int i = 0; i < MLAT; i++) tag_p[i] <= T_BUBBLE;
        end else if (kill) begin
            acc_cnt    <= '0;
            ret_cnt    <= '0;
            last_p1    <= 1'b0;
            last_p2    <= 1'b0;
            out_vld    <= 1'b0;
            dsp_OPMODE <= 8'h08;
            for (int i = 0; i < MLAT; i++) tag_p[i] <= T_BUBBLE;
        end else begin
            if (state == IDLE && start && (cfg_len != '0)) begin
                len_q   <= cfg_len;
                acc_cnt <= '0;
                ret_cnt <= '0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (retire) ret_cnt <= ret_cnt + 1'b1;
            end
            for (int i = MLAT-1; i > 0; i--) tag_p[i] <= tag_p[i-1];
            tag_p[0]   <= tag_in;
            dsp_OPMODE <= tag_opmode(tag_p[MLAT-2]);
            // last_p1: final term enters P; last_p2: P holds the full sum.
            last_p1    <= last_retire;
            last_p2    <= last_p1;
            if (last_p2)                       out_vld <= 1'b1;
            else if (out_vld && mac.out_ready) out_vld <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsp_A  <= '0;
            dsp_B  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                dsp_A <= mac.in_a;
                dsp_B <= mac.in_b;
            end
            if (last_p2 && !kill) result <= dsp_P;
        end
    end

`ifdef MAC_SEQ_ABORT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) dsp_RSTP <= 1'b0;
        else     dsp_RSTP <= kill;
    end
`else
    assign dsp_RSTP = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP48A1 slice and a result scoreboard.
module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic        busy;
    logic [17:0] dsp_A, dsp_B;
    logic [7:0]  dsp_OPMODE;
    logic        dsp_RSTP;
    logic [47:0] dsp_P;
`ifdef MAC_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    dsp_mac_sequencer_if #(.DW(18)) mac ();

    dsp_mac_sequencer #(.DW(18), .LEN_W(8), .MLAT(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .cfg_len    (cfg_len),
        .busy       (busy),
`ifdef MAC_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .mac        (mac.slave),
        .dsp_A      (dsp_A),
        .dsp_B      (dsp_B),
        .dsp_OPMODE (dsp_OPMODE),
        .dsp_RSTP   (dsp_RSTP),
        .dsp_P      (dsp_P)
    );

    always #5 CLK = ~CLK;

    // Behavioural slice: A0/A1, B0/B1, M, OPMODE and P registers, CE tied high.
    logic [17:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [35:0] m  = '0;
    logic [3:0]  op = '0;
    logic [47:0] p  = '0;
    logic [47:0] xm, zm;
    assign xm    = (op[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
    assign zm    = (op[3:2] == 2'b10) ? p : 48'd0;
    assign dsp_P = p;
    always @(posedge CLK) begin
        a0 <= dsp_A; a1 <= a0;
        b0 <= dsp_B; b1 <= b0;
        m  <= a1 * b1;
        op <= dsp_OPMODE[3:0];
        p  <= dsp_RSTP ? 48'd0 : zm + xm;
    end

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, rise_cyc = 0, hs_count = 0, last_acc = 0;
    logic        ov_prev = 1'b0;
    logic [7:0]  op_hist [256];
    logic [47:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] prod(input logic [17:0] a, input logic [17:0] b);
        logic [47:0] wa, wb;
        wa = {30'd0, a};
        wb = {30'd0, b};
        return wa * wb;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        op_hist[cyc % 256] = dsp_OPMODE;
        if (mac.out_valid && !ov_prev) rise_cyc = cyc;
        ov_prev = mac.out_valid;
        if (mac.out_valid && mac.out_ready && !RST) begin
            hs_count++;
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else                chk("out_data", mac.out_data, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic begin_run(input int n, input logic [47:0] exp);
        sb.push_back(exp);
        start   = 1'b1;
        cfg_len = n[7:0];
        tick();
        start   = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input int gap);
        repeat (gap) tick();
        mac.in_valid = 1'b1;
        mac.in_a     = a;
        mac.in_b     = b;
        for (int t = 0; t < 20 && !mac.in_ready; t++) tick();
        if (!mac.in_ready) chk("in_ready_timeout", 0, 1);
        last_acc = cyc + 1;
        tick();
        mac.in_valid = 1'b0;
    endtask

    task automatic wait_hs(input string tag);
        int h0;
        h0 = hs_count;
        for (int t = 0; t < 60 && hs_count == h0; t++) tick();
        chk(tag, hs_count - h0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [17:0] va [4];
        int          gaps [4];
        logic [7:0]  exp_op [8];
        int          k1, h_before;
        logic [47:0] exp;

        mac.in_valid  = 1'b0;
        mac.in_a      = '0;
        mac.in_b      = '0;
        mac.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy",   busy, 0);
        chk("rst_inrdy",  mac.in_ready, 0);
        chk("rst_ovalid", mac.out_valid, 0);
        chk("rst_opmode", dsp_OPMODE, 8'h00);
        chk("rst_dspA",   dsp_A, 0);
        chk("rst_rstp",   dsp_RSTP, 0);
        chk("rst_odata",  mac.out_data, 0);
        RST = 1'b0;
        tick();

        // N=3 back-to-back operands
        begin_run(3, prod(2, 3) + prod(4, 5) + prod(6, 7));
        send(2, 3, 0);
        send(4, 5, 0);
        send(6, 7, 0);
        wait_hs("hs_n3");
        chk("latency_n3", rise_cyc, last_acc + 5);
        chk("busy_fall", busy, 0);
        chk("result_68", mac.out_data, 68);

        // N=4 with gaps 0,3,1 and OPMODE trace
        va     = '{18'd1, 18'd2, 18'd3, 18'd4};
        gaps   = '{0, 0, 3, 1};
        exp_op = '{8'h01, 8'h09, 8'h08, 8'h08, 8'h08, 8'h09, 8'h08, 8'h09};
        exp = '0;
        for (int i = 0; i < 4; i++) exp += prod(va[i], va[i]);
        begin_run(4, exp);
        k1 = 0;
        for (int i = 0; i < 4; i++) begin
            send(va[i], va[i], gaps[i]);
            if (i == 0) k1 = last_acc;
        end
        wait_hs("hs_n4");
        chk("latency_n4", rise_cyc, last_acc + 5);
        for (int i = 0; i < 8; i++) chk("opmode_seq", op_hist[(k1 + 2 + i) % 256], exp_op[i]);

        // N=1 full-scale operands
        begin_run(1, prod(18'h3FFFF, 18'h3FFFF));
        send(18'h3FFFF, 18'h3FFFF, 0);
        wait_hs("hs_n1");
        chk("latency_n1", rise_cyc, last_acc + 5);
        chk("result_max", mac.out_data, 48'h000F_FFF8_0001);

        // N=2 with result held by back-pressure
        mac.out_ready = 1'b0;
        begin_run(2, prod(10, 20) + prod(30, 40));
        send(10, 20, 0);
        send(30, 40, 0);
        for (int t = 0; t < 20 && !mac.out_valid; t++) tick();
        h_before = hs_count;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start   = 1'b1;
                cfg_len = 8'd5;
            end
            tick();
            start = 1'b0;
            chk("hold_valid", mac.out_valid, 1);
            chk("hold_data",  mac.out_data, 1400);
            chk("hold_inrdy", mac.in_ready, 0);
        end
        mac.out_ready = 1'b1;
        wait_hs("hs_hold");
        repeat (4) tick();
        chk("single_hs", hs_count, h_before + 1);
        chk("hold_busy", busy, 0);

        // start with zero length is ignored
        start   = 1'b1;
        cfg_len = 8'd0;
        tick();
        start = 1'b0;
        chk("len0_busy", busy, 0);
        h_before = hs_count;
        repeat (8) tick();
        chk("len0_ovalid", mac.out_valid, 0);
        chk("len0_nohs", hs_count, h_before);

        // asynchronous reset during ACCUM
        begin_run(5, 48'd0);
        send(11, 12, 0);
        send(13, 14, 0);
        RST = 1'b1;
        #1;
        chk("arst_busy",   busy, 0);
        chk("arst_inrdy",  mac.in_ready, 0);
        chk("arst_opmode", dsp_OPMODE, 8'h00);
        chk("arst_dspA",   dsp_A, 0);
        chk("arst_dspB",   dsp_B, 0);
        chk("arst_odata",  mac.out_data, 0);
        sb.delete();
        tick();
        RST = 1'b0;
        tick();
        begin_run(2, prod(3, 3) + prod(5, 5));
        send(3, 3, 0);
        send(5, 5, 0);
        wait_hs("hs_after_rst");
        chk("result_34", mac.out_data, 34);

`ifdef MAC_SEQ_ABORT_EN
        // abort mid-run
        begin_run(4, 48'd0);
        send(21, 22, 0);
        send(23, 24, 0);
        abort = 1'b1;
        #1;
        chk("abort_inrdy", mac.in_ready, 0);
        tick();
        abort = 1'b0;
        sb.delete();
        chk("abort_rstp_hi", dsp_RSTP, 1);
        chk("abort_idle",    busy, 0);
        tick();
        chk("abort_rstp_lo", dsp_RSTP, 0);
        h_before = hs_count;
        repeat (10) tick();
        chk("abort_nohs",   hs_count, h_before);
        chk("abort_ovalid", mac.out_valid, 0);
        chk("abort_odata",  mac.out_data, 34);
        begin_run(1, prod(7, 9));
        send(7, 9, 0);
        wait_hs("hs_after_abort");
        chk("result_63", mac.out_data, 63);
`endif

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
